// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared widths, memory-mode and register-write encodings, FSM states
package mem_access_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int RADDR_WIDTH = 5;
  localparam int MEM_MODE_WIDTH = 3;
  localparam int BE_WIDTH = 4;
  localparam logic [MEM_MODE_WIDTH-1:0] MEM_BYTE = 3'd0;
  localparam logic [MEM_MODE_WIDTH-1:0] MEM_HWORD = 3'd1;
  localparam logic [MEM_MODE_WIDTH-1:0] MEM_WORD = 3'd2;
  localparam logic [MEM_MODE_WIDTH-1:0] MEM_BYTEU = 3'd3;
  localparam logic [MEM_MODE_WIDTH-1:0] MEM_HWORDU = 3'd4;
  localparam logic REG_WR_EN = 1'b0;
  localparam logic REG_WR_DIS = 1'b1;
  typedef enum logic [1:0] {MA_IDLE, MA_REQ, MA_RESP, MA_DONE} ma_state_t;
endpackage

// File: rtl/mem_store_align.sv
// mem_store_align: store byte enables, lane-replicated data and alignment check
module mem_store_align
  import mem_access_pkg::*;
(
  input  logic [MEM_MODE_WIDTH-1:0] mode,
  input  logic [1:0]                addr,
  input  logic [DATA_WIDTH-1:0]     rs2,
  output logic [BE_WIDTH-1:0]       be,
  output logic [DATA_WIDTH-1:0]     wdata,
  output logic                      misaligned
);
  logic half, word;
  always_comb begin
    half = mode == MEM_HWORD || mode == MEM_HWORDU;
    word = mode == MEM_WORD;
    be = word ? 4'b1111 : half ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b0001 << addr;
    wdata = word ? rs2 : half ? {2{rs2[15:0]}} : {4{rs2[7:0]}};
    misaligned = (half & addr[0]) | (word & |addr);
  end
endmodule

// File: rtl/mem_access.sv
// mem_access: memory pipeline stage with dmem handshake, stall control and MEM/WB register
module mem_access
  import mem_access_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ex_valid,
  input  logic                      ex_mem_read,
  input  logic                      ex_mem_write,
  input  logic [MEM_MODE_WIDTH-1:0] ex_mem_mode,
  input  logic                      ex_mem_to_reg,
  input  logic                      ex_reg_web,
  input  logic [RADDR_WIDTH-1:0]    ex_rd,
  input  logic [DATA_WIDTH-1:0]     ex_alu_result,
  input  logic [DATA_WIDTH-1:0]     ex_rs2_data,
  output logic                      mem_stall,
  output logic                      dmem_req,
  output logic                      dmem_we,
  output logic [BE_WIDTH-1:0]       dmem_be,
  output logic [DATA_WIDTH-1:0]     dmem_addr,
  output logic [DATA_WIDTH-1:0]     dmem_wdata,
  input  logic                      dmem_gnt,
  input  logic                      dmem_rvalid,
  input  logic [DATA_WIDTH-1:0]     dmem_rdata,
  output logic                      wb_mem_read,
  output logic                      wb_mem_to_reg,
  output logic                      wb_reg_web,
  output logic [MEM_MODE_WIDTH-1:0] wb_mem_mode,
  output logic [RADDR_WIDTH-1:0]    wb_rd,
  output logic [DATA_WIDTH-1:0]     wb_alu_result,
  output logic [DATA_WIDTH-1:0]     wb_mem_rdata,
  output logic                      misalign_err
);
  ma_state_t state, state_nx;
  logic access, is_load, mis, go;
  logic [BE_WIDTH-1:0] st_be;
  logic [DATA_WIDTH-1:0] st_wdata, rdata_q;
  mem_store_align u_align (
    .mode(ex_mem_mode), .addr(ex_alu_result[1:0]), .rs2(ex_rs2_data),
    .be(st_be), .wdata(st_wdata), .misaligned(mis)
  );
  always_comb begin
    access = ex_valid & (ex_mem_read | ex_mem_write);
    is_load = ex_mem_read & ~ex_mem_write;
    go = state == MA_IDLE && access && !mis;
    mem_stall = go || state == MA_REQ || state == MA_RESP;
    state_nx = go ? MA_REQ
             : state == MA_REQ ? (dmem_gnt ? (is_load ? MA_RESP : MA_DONE) : MA_REQ)
             : state == MA_RESP ? (dmem_rvalid ? MA_DONE : MA_RESP)
             : MA_IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= MA_IDLE;
      dmem_req <= 1'b0;
      dmem_we <= 1'b0;
      dmem_be <= '0;
      dmem_addr <= '0;
      dmem_wdata <= '0;
      rdata_q <= '0;
      misalign_err <= 1'b0;
      wb_mem_read <= 1'b0;
      wb_mem_to_reg <= 1'b0;
      wb_reg_web <= REG_WR_DIS;
      wb_mem_mode <= MEM_WORD;
      wb_rd <= '0;
      wb_alu_result <= '0;
      wb_mem_rdata <= '0;
    end else begin
      state <= state_nx;
      misalign_err <= state == MA_IDLE && access && mis;
      if (go) begin
        dmem_req <= 1'b1;
        dmem_we <= ~is_load;
        dmem_be <= is_load ? '1 : st_be;
        dmem_addr <= {ex_alu_result[DATA_WIDTH-1:2], 2'b00};
        dmem_wdata <= is_load ? '0 : st_wdata;
      end else if (state == MA_REQ && dmem_gnt) dmem_req <= 1'b0;
      if (state == MA_RESP && dmem_rvalid) rdata_q <= dmem_rdata;
      // stalled cycles become bubbles so the register file sees the instruction once
      wb_mem_read <= !mem_stall && ex_valid && is_load;
      wb_mem_to_reg <= !mem_stall && ex_valid && ex_mem_to_reg;
      wb_reg_web <= (mem_stall || !ex_valid || (access && mis)) ? REG_WR_DIS : ex_reg_web;
      wb_mem_mode <= ex_mem_mode;
      wb_rd <= ex_rd;
      wb_alu_result <= ex_alu_result;
      wb_mem_rdata <= (state == MA_DONE && is_load) ? rdata_q : '0;
    end
  end
endmodule
